// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and helper types.
// Used by the sync generator and by the framebuffer reader.
package vga_timing_pkg;

  localparam int unsigned H_SIZE = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SW   = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned V_SIZE = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SW   = 2;
  localparam int unsigned V_BP   = 33;
  localparam logic        H_POL  = 1'b0;
  localparam logic        V_POL  = 1'b0;

  localparam int CNT_W  = 14;
  localparam int ADDR_W = 24;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Length of one axis (line or frame) in counter steps.
  function automatic int unsigned axis_total(input int unsigned size, input int unsigned fp,
                                             input int unsigned sw, input int unsigned bp);
    return size + fp + sw + bp;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(H_SIZE, H_FP, H_SW, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_SIZE, V_FP, V_SW, V_BP);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle between the sync generator (master) and its consumer (slave).
// The consumer supplies the pixel clock enable and the scan direction.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic  PCE;
  logic  Reverse_SW;
  logic  Hsync;
  logic  Vsync;
  logic  DE;
  cnt_t  hpos;
  cnt_t  vpos;
  addr_t addr;
  logic  frame_start;
  logic  line_start;

  modport master (
    input  PCE, Reverse_SW,
    output Hsync, Vsync, DE, hpos, vpos, addr, frame_start, line_start
  );

  modport slave (
    output PCE, Reverse_SW,
    input  Hsync, Vsync, DE, hpos, vpos, addr, frame_start, line_start
  );

endinterface

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrap counter 0..TOTAL-1 with enable, terminal count,
// and decode of the active and sync windows from the current count.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned SIZE = H_SIZE,
  parameter int unsigned FP   = H_FP,
  parameter int unsigned SW   = H_SW,
  parameter int unsigned BP   = H_BP
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output cnt_t cnt_o,
  output logic tc_o,
  output logic act_o,
  output logic sync_o
);

  localparam int unsigned TOTAL = axis_total(SIZE, FP, SW, BP);
  localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
  localparam cnt_t ACT_END = cnt_t'(SIZE);
  localparam cnt_t SYNC_LO = cnt_t'(SIZE + FP);
  localparam cnt_t SYNC_HI = cnt_t'(SIZE + FP + SW - 1);

  cnt_t cnt_q, cnt_d;

  assign tc_o   = (cnt_q == LAST);
  assign act_o  = (cnt_q < ACT_END);
  assign sync_o = (cnt_q >= SYNC_LO) && (cnt_q <= SYNC_HI);
  assign cnt_o  = cnt_q;

  // Next count: advance on enable, wrap after the last position.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/timing generator. Outputs are registered from the current
// (hc,vc) on each enabled edge, so every output lags the counters by one
// enabled cycle and all outputs stay mutually aligned. The framebuffer
// address uses a per-line row base stepped by +/-HSIZE (no multiplier);
// scan direction is latched only at the last pixel of a frame.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned HSIZE = H_SIZE,
  parameter int unsigned HFP   = H_FP,
  parameter int unsigned HSW   = H_SW,
  parameter int unsigned HBP   = H_BP,
  parameter int unsigned VSIZE = V_SIZE,
  parameter int unsigned VFP   = V_FP,
  parameter int unsigned VSW   = V_SW,
  parameter int unsigned VBP   = V_BP,
  parameter logic        HPOL  = H_POL,
  parameter logic        VPOL  = V_POL
) (
  input  logic           CLK,
  input  logic           RESET_N,
  vga_sync_gen_if.master vif
);

  localparam addr_t ROW_STEP = addr_t'(HSIZE);
  localparam addr_t ROW_LAST = addr_t'((VSIZE - 1) * HSIZE);

  cnt_t hc, vc;
  logic h_tc, h_act, h_sync;
  logic v_tc, v_act, v_sync;

  vga_axis_cnt #(.SIZE(HSIZE), .FP(HFP), .SW(HSW), .BP(HBP)) u_h (
    .clk_i (CLK),
    .rst_ni(RESET_N),
    .en_i  (vif.PCE),
    .cnt_o (hc),
    .tc_o  (h_tc),
    .act_o (h_act),
    .sync_o(h_sync)
  );

  vga_axis_cnt #(.SIZE(VSIZE), .FP(VFP), .SW(VSW), .BP(VBP)) u_v (
    .clk_i (CLK),
    .rst_ni(RESET_N),
    .en_i  (vif.PCE & h_tc),
    .cnt_o (vc),
    .tc_o  (v_tc),
    .act_o (v_act),
    .sync_o(v_sync)
  );

  logic  rev_q, rev_d;
  addr_t row_q, row_d;

  // Row base follows vc; direction is captured once per frame at the last pixel.
  // Past the active lines the base keeps stepping but is never used.
  always_comb begin
    rev_d = rev_q;
    row_d = row_q;
    if (vif.PCE && h_tc) begin
      if (v_tc) begin
        rev_d = vif.Reverse_SW;
        row_d = vif.Reverse_SW ? ROW_LAST : '0;
      end else begin
        row_d = rev_q ? row_q - ROW_STEP : row_q + ROW_STEP;
      end
    end
  end

  logic  hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, ls_q, ls_d;
  cnt_t  hpos_q, hpos_d, vpos_q, vpos_d;
  addr_t addr_q, addr_d;

  // Output decode from the pre-edge counter values; everything holds when PCE=0.
  always_comb begin
    hs_d   = hs_q;
    vs_d   = vs_q;
    de_d   = de_q;
    fs_d   = fs_q;
    ls_d   = ls_q;
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    addr_d = addr_q;
    if (vif.PCE) begin
      de_d   = h_act & v_act;
      hs_d   = h_sync ? HPOL : ~HPOL;
      vs_d   = v_sync ? VPOL : ~VPOL;
      hpos_d = hc;
      vpos_d = vc;
      addr_d = (h_act & v_act) ? row_q + addr_t'(hc) : '0;
      fs_d   = (hc == '0) && (vc == '0);
      ls_d   = (hc == '0) && v_act;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rev_q  <= 1'b0;
      row_q  <= '0;
      hs_q   <= ~HPOL;
      vs_q   <= ~VPOL;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      ls_q   <= 1'b0;
      hpos_q <= '0;
      vpos_q <= '0;
      addr_q <= '0;
    end else begin
      rev_q  <= rev_d;
      row_q  <= row_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      fs_q   <= fs_d;
      ls_q   <= ls_d;
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      addr_q <= addr_d;
    end
  end

  assign vif.Hsync       = hs_q;
  assign vif.Vsync       = vs_q;
  assign vif.DE          = de_q;
  assign vif.hpos        = hpos_q;
  assign vif.vpos        = vpos_q;
  assign vif.addr        = addr_q;
  assign vif.frame_start = fs_q;
  assign vif.line_start  = ls_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken timing (16x11) so whole frames are
// cheap. Reference model works from a linear count of enabled edges and
// derives position, sync windows and address with plain arithmetic.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int HS = 8, HF = 2, HW = 3, HB = 3;
  localparam int VS = 6, VF = 1, VW = 2, VB = 2;
  localparam logic HP = 1'b0, VP = 1'b1;
  localparam int HT = HS + HF + HW + HB;
  localparam int VT = VS + VF + VW + VB;
  localparam int FT = HT * VT;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  vga_sync_gen_if vif();

  vga_sync_gen #(
    .HSIZE(HS), .HFP(HF), .HSW(HW), .HBP(HB),
    .VSIZE(VS), .VFP(VF), .VSW(VW), .VBP(VB),
    .HPOL(HP), .VPOL(VP)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .vif    (vif)
  );

  always #5 CLK = ~CLK;

  int   n_tst = 0;
  int   n_fail = 0;
  int   cnt;        // enabled edges since reset
  logic m_rev;      // direction of the frame currently on the outputs
  logic m_rev_nxt;  // direction latched for the next frame

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tst++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model.
  task automatic chk_all();
    int p, h, v, e_ad;
    logic e_de, e_hs, e_vs, e_fs, e_ls;
    if (cnt == 0) begin
      h = 0; v = 0; e_ad = 0;
      e_de = 1'b0; e_hs = ~HP; e_vs = ~VP; e_fs = 1'b0; e_ls = 1'b0;
    end else begin
      p    = cnt - 1;
      h    = p % HT;
      v    = (p / HT) % VT;
      e_de = (h < HS) && (v < VS);
      e_hs = (h >= HS + HF && h < HS + HF + HW) ? HP : ~HP;
      e_vs = (v >= VS + VF && v < VS + VF + VW) ? VP : ~VP;
      e_fs = (h == 0) && (v == 0);
      e_ls = (h == 0) && (v < VS);
      if (!e_de)     e_ad = 0;
      else if (m_rev) e_ad = (VS - 1 - v) * HS + h;
      else           e_ad = v * HS + h;
    end
    chk("DE",          32'(vif.DE),          32'(e_de));
    chk("Hsync",       32'(vif.Hsync),       32'(e_hs));
    chk("Vsync",       32'(vif.Vsync),       32'(e_vs));
    chk("hpos",        32'(vif.hpos),        32'(h));
    chk("vpos",        32'(vif.vpos),        32'(v));
    chk("addr",        32'(vif.addr),        32'(e_ad));
    chk("frame_start", 32'(vif.frame_start), 32'(e_fs));
    chk("line_start",  32'(vif.line_start),  32'(e_ls));
  endtask

  // One clock from a negedge: drive, advance model on enabled edges, check.
  task automatic step(input logic pce, input logic rev);
    vif.PCE        = pce;
    vif.Reverse_SW = rev;
    @(posedge CLK);
    if (pce) begin
      if (cnt % FT == 0)      m_rev = m_rev_nxt;
      if (cnt % FT == FT - 1) m_rev_nxt = rev;
      cnt++;
    end
    @(negedge CLK);
    chk_all();
  endtask

  task automatic model_reset();
    cnt = 0; m_rev = 1'b0; m_rev_nxt = 1'b0;
  endtask

  initial begin
    logic rv;
    int   n;
    rv = 1'b0;
    vif.PCE = 1'b0;
    vif.Reverse_SW = 1'b0;
    model_reset();

    // Held in reset with the clock running.
    repeat (3) @(negedge CLK);
    vif.PCE = 1'b1;
    @(negedge CLK);
    chk_all();

    // First enabled edge after release: origin of the frame.
    RESET_N = 1'b1;
    step(1'b1, 1'b0);
    chk("first_addr", 32'(vif.addr), 32'd0);
    chk("first_fs",   32'(vif.frame_start), 32'd1);

    // Enable gaps must freeze everything.
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);

    // Reverse held high: frame 0 stays forward, frame 1 runs bottom-up.
    for (int i = 0; i < 3 * FT; i++) step($urandom_range(0, 3) != 0, 1'b1);

    // Random enables with occasional direction flips.
    rv = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 39) == 0) rv = ~rv;
      step($urandom_range(0, 3) != 0, rv);
    end

    // Flip direction mid-frame (line 3); must only apply from the next frame.
    n = 0;
    while (!((cnt - 1) % FT == 3 * HT + 1) && n < 2 * FT) begin
      step(1'b1, rv); n++;
    end
    chk("reach_line3", 32'(n < 2 * FT), 32'd1);
    rv = ~rv;
    for (int i = 0; i < FT + 2 * HT; i++) step($urandom_range(0, 3) != 0, rv);

    // Asynchronous reset mid-frame at line 4, column 5.
    n = 0;
    while (!((cnt - 1) % FT == 4 * HT + 5) && n < 2 * FT) begin
      step(1'b1, rv); n++;
    end
    chk("reach_mid", 32'(n < 2 * FT), 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    model_reset();
    chk_all();
    @(negedge CLK);
    chk_all();
    RESET_N = 1'b1;
    step(1'b1, rv);
    chk("rst_de", 32'(vif.DE),          32'd1);
    chk("rst_fs", 32'(vif.frame_start), 32'd1);
    chk("rst_ls", 32'(vif.line_start),  32'd1);
    chk("rst_ad", 32'(vif.addr),        32'd0);
    for (int i = 0; i < 2 * FT; i++) begin
      if ($urandom_range(0, 39) == 0) rv = ~rv;
      step($urandom_range(0, 3) != 0, rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tst, n_fail);
    $finish;
  end

endmodule
